sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO: storage array plus write/read pointer control, full/empty detection, occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Next generation of the team's raw dual-port FIFO memory; used wherever producer and consumer share one clock domain. Depth scales with ADD_WIDTH, and the data path scales with DATA_WIDTH.

---
 rtl/sync_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: storage, pointers, occupancy, thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADD_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADD_WIDTH;
    localparam logic [ADD_WIDTH:0] AF_CNT = AF_LEVEL[ADD_WIDTH:0];
    localparam logic [ADD_WIDTH:0] AE_CNT = AE_LEVEL[ADD_WIDTH:0];

    logic [ADD_WIDTH:0]    wr_ptr_reg;
    logic [ADD_WIDTH:0]    rd_ptr_reg;
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  wr_accept;
    logic                  rd_accept;

    // The extra pointer MSB distinguishes full from empty when the low bits match.
    assign count        = wr_ptr_reg - rd_ptr_reg;
    assign empty        = (wr_ptr_reg == rd_ptr_reg);
    assign full         = (wr_ptr_reg[ADD_WIDTH] != rd_ptr_reg[ADD_WIDTH]) &&
                          (wr_ptr_reg[ADD_WIDTH-1:0] == rd_ptr_reg[ADD_WIDTH-1:0]);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign wr_accept    = wr_en && !full;
    assign rd_accept    = rd_en && !empty;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_accept) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    mem_reg[gi] <= '0;
                else if (wr_accept && (wr_ptr_reg[ADD_WIDTH-1:0] == ADD_WIDTH'(gi)))
                    mem_reg[gi] <= data_in;
            end
        end
    endgenerate

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem_reg[rd_ptr_reg[ADD_WIDTH-1:0]];
    assign rd_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  rd_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_reg <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
            if (rd_accept) data_out_reg <= mem_reg[rd_ptr_reg[ADD_WIDTH-1:0]];
        end
    end

    assign data_out = data_out_reg;
    assign rd_valid = rd_valid_reg;
`endif

    // A set event on the same edge as err_clr takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en && full)       overflow_reg <= 1'b1;
            else if (err_clr)        overflow_reg <= 1'b0;
            if (rd_en && empty)      underflow_reg <= 1'b1;
            else if (err_clr)        underflow_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADD_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .err_clr(err_clr), .data_out(data_out), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, outputs derived from occupancy.
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_valid, m_ovf, m_udf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_dout = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            automatic bit was_full  = (q.size() == 8);
            automatic bit was_empty = (q.size() == 0);
            automatic bit wa = wr_en && !was_full;
            automatic bit ra = rd_en && !was_empty;
            m_valid = ra;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(data_in);
            if (wr_en && was_full) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
            if (rd_en && was_empty) m_udf = 1'b1; else if (err_clr) m_udf = 1'b0;
        end
    end

    always @(negedge clk) begin
        automatic int n = q.size();
        automatic logic [7:0] e_dout;
        automatic logic e_valid;
`ifdef SYNC_FIFO_FWFT_EN
        e_dout  = (n != 0) ? q[0] : 8'h00;
        e_valid = (n != 0);
`else
        e_dout  = m_dout;
        e_valid = m_valid;
`endif
        chk("model_count", 32'(count), 32'(n));
        chk("model_empty", 32'(empty), 32'(n == 0));
        chk("model_full", 32'(full), 32'(n == 8));
        chk("model_af", 32'(almost_full), 32'(n >= 6));
        chk("model_ae", 32'(almost_empty), 32'(n <= 2));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
        chk("model_udf", 32'(underflow), 32'(m_udf));
        chk("model_rd_valid", 32'(rd_valid), 32'(e_valid));
        chk("model_data_out", 32'(data_out), 32'(e_dout));
    end

    // Apply one cycle of inputs; returns at the following negedge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en = w; data_in = d; rd_en = r; err_clr = c;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        $display("cycle wr=%0b din=%02h rd=%0b clr=%0b -> cnt=%0d dout=%02h vld=%0b ovf=%0b udf=%0b",
                 w, d, r, c, count, data_out, rd_valid, overflow, underflow);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_ae", 32'(almost_empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        rst = 1'b0;

        // 1: fill with 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_ae", 32'(almost_empty), 32'(i < 2));
            chk("fill_af", 32'(almost_full), 32'(i >= 5));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf", 32'(overflow), 32'd0);

        // 2: overflow, then drain in order
        step(1'b1, 8'h99, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", 32'(data_out), 32'(8'h11 + i));
`endif
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // 3: underflow and its clear
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_valid", 32'(rd_valid), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("udf_dout", 32'(data_out), 32'h00);
`else
        chk("udf_dout", 32'(data_out), 32'h18);
`endif
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("udf_set_wins", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_clr", 32'(underflow), 32'd0);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // 4: pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("wrap_count", 32'(count), 32'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("wrap_last", 32'(data_out), 32'h36);
`endif
        chk("wrap_empty", 32'(empty), 32'd1);

        // 5: simultaneous push/pop at count 4, then at full
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
            chk("both_count", 32'(count), 32'd4);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("both_full", 32'(full), 32'd1);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("both_full_count", 32'(count), 32'd7);
        chk("both_full_ovf", 32'(overflow), 32'd1);

        // 6: asynchronous reset with count 5
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_dout", 32'(data_out), 32'h00);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        chk("rst_blocks_write", 32'(count), 32'd0);
        rst = 1'b0;

`ifdef SYNC_FIFO_FWFT_EN
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_dout", 32'(data_out), 32'hA5);
        chk("fwft_valid", 32'(rd_valid), 32'd1);
`else
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("reg_no_fallthrough", 32'(rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("reg_read_dout", 32'(data_out), 32'hA5);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
